// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, command opcodes, ALU selops.
// SUB support is compiled in only when ALU_SEQ_SUB_EN is defined.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SUB2 = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Opcodes 0xxx pass xxx straight to the ALU; only these two are special.
  typedef enum logic [3:0] {
    OP_SUB = 4'b1000,
    OP_LDI = 4'b1001
  } op_e;

  typedef enum logic [2:0] {
    SEL_PASSB = 3'd0,
    SEL_AND   = 3'd1,
    SEL_OR    = 3'd2,
    SEL_XOR   = 3'd3,
    SEL_NOTA  = 3'd4,
    SEL_ADD   = 3'd5,
    SEL_INCA  = 3'd6,
    SEL_NEGB  = 3'd7
  } sel_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file: two combinational read ports, one synchronous write port.
// Synchronous active-high reset clears every entry.
module alu_seq_regfile #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   ra_addr_i,
  output logic [N-1:0] ra_data_o,
  input  logic [1:0]   rb_addr_i,
  output logic [N-1:0] rb_data_o,
  input  logic         we_i,
  input  logic [1:0]   wa_i,
  input  logic [N-1:0] wd_i
);

  logic [N-1:0] regs_q [4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single commands through an external ALU, one in flight at a time.
// Define ALU_SEQ_SUB_EN to build the two-pass SUB (negate, then add) path.
//
// state  | meaning
// S_IDLE | waiting for a command, cmd_ready high
// S_EXEC | drive ALU with R[rd]/R[rs] (or -R[rs] for SUB), capture result
// S_SUB2 | SUB second pass: R[rd] + T
// S_RESP | hold response until rsp_ready
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_rs,
  input  logic [N-1:0] cmd_imm,
  output logic [N-1:0] alu_dataa,
  output logic [N-1:0] alu_datab,
  output logic [2:0]   alu_selop,
  input  logic [N-1:0] alu_result,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_carry,
  output logic         rsp_err
);

  state_e       state_q, state_d;
  logic [3:0]   op_q;
  logic [1:0]   rd_q, rs_q;
  logic [N-1:0] imm_q;
  logic [N-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic         rsp_err_q, rsp_err_d;
  logic [N-1:0] ra_data, rb_data;
  logic         rf_we;
  logic [N-1:0] rf_wd;
  logic         is_sub;
`ifdef ALU_SEQ_SUB_EN
  logic [N-1:0] t_q, t_d;
  assign is_sub = (op_q == OP_SUB);
`else
  assign is_sub = 1'b0;
`endif

  alu_seq_regfile #(.N(N)) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .ra_addr_i (rd_q),
    .ra_data_o (ra_data),
    .rb_addr_i (rs_q),
    .rb_data_o (rb_data),
    .we_i      (rf_we),
    .wa_i      (rd_q),
    .wd_i      (rf_wd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_EXEC;
      S_EXEC: state_d = is_sub ? S_SUB2 : S_RESP;
      S_SUB2: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_dataa   = '0;
    alu_datab   = '0;
    alu_selop   = SEL_PASSB;
    rf_we       = 1'b0;
    rf_wd       = alu_result;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_SEQ_SUB_EN
    t_d         = t_q;
`endif
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        if (is_alu_op(op_q)) begin
          alu_dataa   = ra_data;
          alu_datab   = rb_data;
          alu_selop   = op_q[2:0];
          rf_we       = 1'b1;
          rsp_data_d  = alu_result;
          rsp_carry_d = alu_cout;
          rsp_err_d   = 1'b0;
        end else if (op_q == OP_LDI) begin
          rf_we       = 1'b1;
          rf_wd       = imm_q;
          rsp_data_d  = imm_q;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
`ifdef ALU_SEQ_SUB_EN
        else if (op_q == OP_SUB) begin
          alu_datab = rb_data;
          alu_selop = SEL_NEGB;
          t_d       = alu_result;
        end
`endif
        else begin
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b1;
        end
      end
`ifdef ALU_SEQ_SUB_EN
      S_SUB2: begin
        alu_dataa   = ra_data;
        alu_datab   = t_q;
        alu_selop   = SEL_ADD;
        rf_we       = 1'b1;
        rsp_data_d  = alu_result;
        rsp_carry_d = alu_cout;
        rsp_err_d   = 1'b0;
      end
`endif
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
    end else if (cmd_valid && state_q == S_IDLE) begin
      op_q  <= cmd_op;
      rd_q  <= cmd_rd;
      rs_q  <= cmd_rs;
      imm_q <= cmd_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_SEQ_SUB_EN
      t_q         <= '0;
`endif
    end else begin
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_SEQ_SUB_EN
      t_q         <= t_d;
`endif
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule
